// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared sequencer state encoding for the iterative divider
package seq_divider_pkg;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] STATE_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] STATE_CALC = 2'd1;
   localparam logic [STATE_W-1:0] STATE_FIN  = 2'd2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = STATE_IDLE,
      ST_CALC = STATE_CALC,
      ST_FIN  = STATE_FIN
   } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring-division step
module div_step #(
   parameter int WIDTH = 10
) (
   input  logic [WIDTH-1:0] acc_in,
   input  logic             msb_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] acc_out,
   output logic             q_bit
);

   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] diff;

   // The trial value is one bit wider than the operands so the compare cannot wrap;
   // when it succeeds the true difference is below divisor and fits in WIDTH bits.
   always_comb begin
      trial   = {acc_in, msb_in};
      diff    = trial[WIDTH-1:0] - divisor;
      q_bit   = (trial >= {1'b0, divisor});
      acc_out = q_bit ? diff : trial[WIDTH-1:0];
   end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative unsigned restoring divider, one quotient bit per clock
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   state_e           state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [WIDTH-1:0] acc_q,     acc_d;
   logic [WIDTH-1:0] q_q,       q_d;
   logic [WIDTH-1:0] dvsr_q,    dvsr_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;
   logic             dbz_q,     dbz_d;
   logic [WIDTH-1:0] quot_q,    quot_d;
   logic [WIDTH-1:0] rem_q,     rem_d;

   logic [WIDTH-1:0] step_acc;
   logic             step_bit;
   logic [WIDTH-1:0] q_shifted;

   div_step #(.WIDTH(WIDTH)) u_step (
      .acc_in  (acc_q),
      .msb_in  (q_q[WIDTH-1]),
      .divisor (dvsr_q),
      .acc_out (step_acc),
      .q_bit   (step_bit)
   );

   assign q_shifted = {q_q[WIDTH-2:0], step_bit};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      q_d     = q_q;
      dvsr_d  = dvsr_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      quot_d  = quot_q;
      rem_d   = rem_q;

      case (state_q)
         ST_IDLE, ST_FIN: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            if (start) begin
               // A zero divisor skips iteration and reports the conventional all-ones result.
               if (divisor == '0) begin
                  state_d = ST_FIN;
                  done_d  = 1'b1;
                  dbz_d   = 1'b1;
                  quot_d  = '1;
                  rem_d   = dividend;
               end else begin
                  state_d = ST_CALC;
                  busy_d  = 1'b1;
                  dbz_d   = 1'b0;
                  acc_d   = '0;
                  q_d     = dividend;
                  dvsr_d  = divisor;
                  cnt_d   = CNT_W'(WIDTH);
               end
            end
         end
         ST_CALC: begin
            acc_d = step_acc;
            q_d   = q_shifted;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_FIN;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               quot_d  = q_shifted;
               rem_d   = step_acc;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         dvsr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         dvsr_q  <= dvsr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider with a behavioural model
module tb_seq_divider;

   localparam int W = 10;
   localparam int LAT = W + 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int n_checks = 0;
   int n_fail = 0;
   bit check_en = 1'b0;

   seq_divider #(.WIDTH(W), .CNT_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Behavioural model: results from plain / and %, timing from the cycle budget.
   bit         m_busy = 0, m_done = 0, m_dbz = 0;
   int         m_q = 0, m_r = 0, m_left = 0, pend_q = 0, pend_r = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_dbz = 0; m_q = 0; m_r = 0; m_left = 0;
      end else begin
         m_done = 0;
         if (!m_busy && start) begin
            if (divisor == 0) begin
               m_done = 1; m_dbz = 1; m_q = (1 << W) - 1; m_r = int'(dividend);
            end else begin
               m_busy = 1; m_dbz = 0;
               pend_q = int'(dividend) / int'(divisor);
               pend_r = int'(dividend) % int'(divisor);
               m_left = W;
            end
         end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 0; m_done = 1; m_q = pend_q; m_r = pend_r;
            end
         end
      end
      check_en = 1'b1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         check("model_busy", int'(busy), int'(m_busy));
         check("model_done", int'(done), int'(m_done));
         check("model_dbz", int'(div_by_zero), int'(m_dbz));
         check("model_quotient", int'(quotient), m_q);
         check("model_remainder", int'(remainder), m_r);
      end
   end

   // Launch one divide and count cycles until done; optionally poke start mid-operation.
   task automatic run_div(input int a, input int b, input int eq, input int er, input int elat,
                          input int poke_at, input int pa, input int pb);
      int n;
      @(negedge clk);
      start = 1'b1; dividend = W'(a); divisor = W'(b);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            start = 1'b0;
            check("busy_after_accept", int'(busy), (b == 0) ? 0 : 1);
         end
         if (n == poke_at) begin
            start = 1'b1; dividend = W'(pa); divisor = W'(pb);
         end else if (n == poke_at + 1) begin
            start = 1'b0;
         end
      end while (!done && n < 40);
      check("latency", n, elat);
      check("quotient", int'(quotient), eq);
      check("remainder", int'(remainder), er);
      check("div_by_zero", int'(div_by_zero), (b == 0) ? 1 : 0);
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_quotient", int'(quotient), 0);
      check("reset_remainder", int'(remainder), 0);
      rst_n = 1'b1;

      run_div(100, 7, 14, 2, LAT, 0, 0, 0);
      run_div(37, 0, 1023, 37, 1, 0, 0, 0);
      run_div(1023, 1, 1023, 0, LAT, 0, 0, 0);
      run_div(5, 9, 0, 5, LAT, 0, 0, 0);
      run_div(1023, 1023, 1, 0, LAT, 0, 0, 0);
      run_div(0, 3, 0, 0, LAT, 0, 0, 0);
      run_div(100, 7, 14, 2, LAT, 4, 50, 5);

      // Reset mid-divide: everything clears and no done appears.
      @(negedge clk);
      start = 1'b1; dividend = W'(100); divisor = W'(7);
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_busy", int'(busy), 0);
      check("abort_quotient", int'(quotient), 0);
      check("abort_remainder", int'(remainder), 0);
      repeat (12) begin
         @(negedge clk);
         check("abort_no_done", int'(done), 0);
      end
      run_div(9, 2, 4, 1, LAT, 0, 0, 0);

      // Back-to-back: start held on the done cycle.
      run_div(100, 7, 14, 2, LAT, 0, 0, 0);
      start = 1'b1; dividend = W'(60); divisor = W'(8);
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", int'(busy), 1);
      check("b2b_done_dropped", int'(done), 0);
      n = 1;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("b2b_latency", n, LAT);
      check("b2b_quotient", int'(quotient), 7);
      check("b2b_remainder", int'(remainder), 4);

      // Random traffic, including zero divisors, starts while busy and stray resets.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         dividend = W'($urandom_range(0, (1 << W) - 1));
         case ($urandom_range(0, 7))
            0:       divisor = '0;
            1:       divisor = W'($urandom_range(1, 4));
            2:       divisor = '1;
            default: divisor = W'($urandom_range(0, (1 << W) - 1));
         endcase
         rst_n = ($urandom_range(0, 199) != 0);
      end
      @(negedge clk);
      rst_n = 1'b1; start = 1'b0;
      repeat (LAT + 2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
